// File: rtl/muxer_unitary_arb.sv
// -----------------------------------------------------------------------------
// muxer_unitary_arb
//
// Registered N-source bus merger for the shared readback bus. It works in one
// of two compile-time modes:
//   MODE 0 : wired-AND of every enabled source. A disabled source reads as
//            all-ones.
//   MODE 1 : round-robin single owner. The scan starts at an internal pointer
//            and wraps from NUM-1 back to 0.
// Every output is registered, so there is exactly one clock of latency and no
// combinational path from input to output.
//
// Optional feature: define MUXER_CONFLICT_CNT_EN to add a saturating
// multi-driver counter (conflict_cnt) and its synchronous clear (clr_cnt).
// When the macro is not defined, clr_cnt is ignored and conflict_cnt is absent.
//
// Parameters:
//   WIDTH  data width per source
//   NUM    number of sources (>= 2)
//   MODE   0 = wired-AND, 1 = round-robin grant
//   IDX_W  owner index width
//   CNT_W  conflict counter width
//
// Ports:
//   clk          in   clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   data_in_bus  in   NUM*WIDTH, source i at [i*WIDTH +: WIDTH]
//   ena_in_bus   in   NUM per-source drive enables
//   clr_cnt      in   synchronous clear of conflict_cnt
//   data_out     out  merged data (all-ones when idle)
//   valid_out    out  any enable was high in the sampled cycle
//   owner_out    out  granted index (MODE 1) or lowest enabled index (MODE 0);
//                     holds its value when nothing is enabled
//   conflict     out  more than one enable was high in the sampled cycle
//   conflict_cnt out  saturating conflict count (MUXER_CONFLICT_CNT_EN only)
// -----------------------------------------------------------------------------
module muxer_unitary_arb #(
  parameter int WIDTH = 8,
  parameter int NUM   = 4,
  parameter int MODE  = 0,
  parameter int IDX_W = $clog2(NUM),
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM*WIDTH-1:0] data_in_bus,
  input  logic [NUM-1:0]       ena_in_bus,
  input  logic                 clr_cnt,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  output logic [IDX_W-1:0]     owner_out,
  output logic                 conflict
`ifdef MUXER_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0]     conflict_cnt
`endif
);

  localparam bit RR = (MODE != 0);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [IDX_W-1:0] r_owner;
  logic             r_conflict;
  logic [IDX_W-1:0] r_ptr;

  logic [WIDTH-1:0] w_and;
  logic [IDX_W-1:0] w_low;
  logic [IDX_W-1:0] w_grant;
  logic             w_found;
  logic [WIDTH-1:0] w_gdata;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic             w_any;
  logic             w_multi;

  assign w_any   = |ena_in_bus;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = |(ena_in_bus & (ena_in_bus - NUM'(1)));

  always_comb begin
    w_and   = '1;
    w_low   = '0;
    w_grant = r_ptr;
    w_found = 1'b0;
    w_gdata = '1;

    for (int i = 0; i < NUM; i++) begin
      w_and = w_and & (data_in_bus[i*WIDTH +: WIDTH] | ~{WIDTH{ena_in_bus[i]}});
    end

    for (int i = NUM - 1; i >= 0; i--) begin
      if (ena_in_bus[i]) w_low = IDX_W'(i);
    end

    // Rotating scan from r_ptr. One extra bit holds ptr+k before the wrap, so
    // a NUM that is not a power of two still wraps at NUM-1.
    for (int k = 0; k < NUM; k++) begin
      logic [IDX_W:0] sum;
      sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM)) sum = sum - (IDX_W+1)'(NUM);
      if (!w_found && ena_in_bus[sum[IDX_W-1:0]]) begin
        w_grant = sum[IDX_W-1:0];
        w_found = 1'b1;
      end
    end

    for (int j = 0; j < NUM; j++) begin
      if (IDX_W'(j) == w_grant) w_gdata = data_in_bus[j*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_nxt = (w_grant == IDX_W'(NUM - 1)) ? '0 : w_grant + IDX_W'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data     <= '1;
      r_valid    <= 1'b0;
      r_owner    <= '0;
      r_conflict <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_data     <= RR ? (w_found ? w_gdata : '1) : w_and;
      r_valid    <= w_any;
      r_conflict <= w_multi;
      if (w_any) r_owner <= RR ? w_grant : w_low;
      if (RR && w_found) r_ptr <= w_ptr_nxt;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign owner_out = r_owner;
  assign conflict  = r_conflict;

`ifdef MUXER_CONFLICT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // A clear wins over an increment on the same edge. The count stops at all-ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_multi && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign conflict_cnt = r_cnt;
`else
  // Without the counter, clr_cnt and CNT_W have no function.
  logic [CNT_W:0] w_unused;
  assign w_unused = {clr_cnt, {CNT_W{1'b0}}};
`endif

endmodule

// File: tb/tb_muxer_unitary_arb.sv
module tb_muxer_unitary_arb;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clr;
  logic [3:0]  ena4;
  logic [31:0] dat4;

  logic [7:0]  d0, d1, d3;
  logic        v0, v1, v3;
  logic [1:0]  o0, o1, o3;
  logic        c0, c1, c3;
`ifdef MUXER_CONFLICT_CNT_EN
  logic [CW-1:0] k0, k1, k3;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state, one entry per DUT: 0 = MODE0/NUM4, 1 = MODE1/NUM4, 2 = MODE1/NUM3
  int          mp[3];
  int          mo[3];
  int          mc[3];
  logic [7:0]  ex_d[3];
  bit          ex_v[3];
  bit          ex_c[3];

  always #5 clk = ~clk;

  muxer_unitary_arb #(.WIDTH(8), .NUM(4), .MODE(0), .CNT_W(CW)) u_m0 (
    .clk(clk), .n_rst(n_rst), .data_in_bus(dat4), .ena_in_bus(ena4), .clr_cnt(clr),
    .data_out(d0), .valid_out(v0), .owner_out(o0), .conflict(c0)
`ifdef MUXER_CONFLICT_CNT_EN
    , .conflict_cnt(k0)
`endif
  );

  muxer_unitary_arb #(.WIDTH(8), .NUM(4), .MODE(1), .CNT_W(CW)) u_m1 (
    .clk(clk), .n_rst(n_rst), .data_in_bus(dat4), .ena_in_bus(ena4), .clr_cnt(clr),
    .data_out(d1), .valid_out(v1), .owner_out(o1), .conflict(c1)
`ifdef MUXER_CONFLICT_CNT_EN
    , .conflict_cnt(k1)
`endif
  );

  muxer_unitary_arb #(.WIDTH(8), .NUM(3), .MODE(1), .CNT_W(CW)) u_m3 (
    .clk(clk), .n_rst(n_rst), .data_in_bus(dat4[23:0]), .ena_in_bus(ena4[2:0]), .clr_cnt(clr),
    .data_out(d3), .valid_out(v3), .owner_out(o3), .conflict(c3)
`ifdef MUXER_CONFLICT_CNT_EN
    , .conflict_cnt(k3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One sampled cycle, computed from the stated merge rules.
  task automatic ref_step(input int num, input int mode, input logic [3:0] ena,
                          input logic [31:0] dat, input bit clr_i,
                          inout int ptr, inout int own, inout int cnt,
                          output logic [7:0] dx, output bit vx, output bit cx);
    int n_en;
    int g;
    n_en = 0;
    for (int i = 0; i < num; i++) if (ena[i]) n_en++;
    vx = (n_en > 0);
    cx = (n_en > 1);
    dx = 8'hFF;
    g  = -1;
    if (mode == 0) begin
      for (int i = 0; i < num; i++) begin
        if (ena[i]) begin
          dx = dx & dat[i*8 +: 8];
          if (g < 0) g = i;
        end
      end
    end else begin
      for (int k = 0; k < num; k++) begin
        int j;
        j = (ptr + k) % num;
        if (g < 0 && ena[j]) g = j;
      end
      if (g >= 0) begin
        dx  = dat[g*8 +: 8];
        ptr = (g + 1) % num;
      end
    end
    if (g >= 0) own = g;
    if (clr_i) cnt = 0;
    else if (cx && cnt < (1 << CW) - 1) cnt = cnt + 1;
  endtask

  task automatic compare_all();
    chk("m0.data",  d0, ex_d[0]);
    chk("m0.valid", v0, ex_v[0]);
    chk("m0.owner", o0, mo[0]);
    chk("m0.confl", c0, ex_c[0]);
    chk("m1.data",  d1, ex_d[1]);
    chk("m1.valid", v1, ex_v[1]);
    chk("m1.owner", o1, mo[1]);
    chk("m1.confl", c1, ex_c[1]);
    chk("m3.data",  d3, ex_d[2]);
    chk("m3.valid", v3, ex_v[2]);
    chk("m3.owner", o3, mo[2]);
    chk("m3.confl", c3, ex_c[2]);
`ifdef MUXER_CONFLICT_CNT_EN
    chk("m0.cnt", k0, mc[0]);
    chk("m1.cnt", k1, mc[1]);
    chk("m3.cnt", k3, mc[2]);
`endif
  endtask

  task automatic cyc(input logic [3:0] e, input logic [31:0] d, input bit c);
    ena4 = e;
    dat4 = d;
    clr  = c;
    @(posedge clk);
    #1;
    ref_step(4, 0, e, d, c, mp[0], mo[0], mc[0], ex_d[0], ex_v[0], ex_c[0]);
    ref_step(4, 1, e, d, c, mp[1], mo[1], mc[1], ex_d[1], ex_v[1], ex_c[1]);
    ref_step(3, 1, {1'b0, e[2:0]}, {8'h00, d[23:0]}, c, mp[2], mo[2], mc[2],
             ex_d[2], ex_v[2], ex_c[2]);
    compare_all();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".m0.data"},  d0, 32'hFF);
    chk({tag, ".m0.valid"}, v0, 0);
    chk({tag, ".m0.owner"}, o0, 0);
    chk({tag, ".m0.confl"}, c0, 0);
    chk({tag, ".m1.data"},  d1, 32'hFF);
    chk({tag, ".m1.valid"}, v1, 0);
    chk({tag, ".m1.owner"}, o1, 0);
    chk({tag, ".m1.confl"}, c1, 0);
    chk({tag, ".m3.data"},  d3, 32'hFF);
    chk({tag, ".m3.owner"}, o3, 0);
`ifdef MUXER_CONFLICT_CNT_EN
    chk({tag, ".m1.cnt"}, k1, 0);
`endif
  endtask

  // Pull reset between edges, check that the outputs react with no clock, then release.
  task automatic async_reset();
    #2;
    n_rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      mp[i] = 0;
      mo[i] = 0;
      mc[i] = 0;
    end
    check_reset("rst_mid");
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    int rot1[5];
    int rot3[5];
    rot1 = '{0, 1, 2, 3, 0};
    rot3 = '{0, 1, 2, 0, 1};
    for (int i = 0; i < 3; i++) begin
      mp[i] = 0;
      mo[i] = 0;
      mc[i] = 0;
    end
    n_rst = 1'b1;
    ena4  = '0;
    dat4  = '1;
    clr   = 1'b0;
    #1 n_rst = 1'b0;
    #1 check_reset("rst_init");
    #1 n_rst = 1'b1;

    // Wired-AND merge: ch0=F0, ch2=3C, with ch1 and ch3 disabled
    cyc(4'b0101, 32'hAA3C55F0, 1'b0);
    chk("m0_merge.data",  d0, 32'h30);
    chk("m0_merge.valid", v0, 1);
    chk("m0_merge.owner", o0, 0);
    chk("m0_merge.confl", c0, 1);
    cyc(4'b0000, 32'h12345678, 1'b0);
    chk("m0_idle.data",  d0, 32'hFF);
    chk("m0_idle.valid", v0, 0);
    chk("m0_idle.confl", c0, 0);
    chk("m0_idle.owner", o0, 0);

    // Round-robin rotation starting from reset
    async_reset();
    for (int n = 0; n < 5; n++) begin
      cyc(4'b1111, 32'h13121110, 1'b0);
      chk("m1_rot.owner", o1, rot1[n]);
      chk("m1_rot.data",  d1, 32'h10 + rot1[n]);
      chk("m1_rot.confl", c1, 1);
      chk("m3_rot.owner", o3, rot3[n]);
    end

    // Wrap and skip: the pointer is now 1
    cyc(4'b1001, 32'hA3A2A1A0, 1'b0);
    chk("m1_wrap.owner", o1, 3);
    chk("m1_wrap.data",  d1, 32'hA3);
    cyc(4'b1001, 32'hA3A2A1A0, 1'b0);
    chk("m1_wrap2.owner", o1, 0);
    cyc(4'b0000, 32'hA3A2A1A0, 1'b0);
    chk("m1_hold.valid", v1, 0);
    chk("m1_hold.owner", o1, 0);
    cyc(4'b1111, 32'hA3A2A1A0, 1'b0);
    chk("m1_ptrheld.owner", o1, 1);

    // Long conflict run, then a clear during a conflict cycle
    async_reset();
    for (int n = 0; n < 20; n++) cyc(4'b1111, $urandom, 1'b0);
`ifdef MUXER_CONFLICT_CNT_EN
    chk("cnt_sat", k1, 15);
`endif
    cyc(4'b0111, $urandom, 1'b1);
`ifdef MUXER_CONFLICT_CNT_EN
    chk("cnt_clr", k1, 0);
`endif

    // Random traffic with occasional clears and mid-stream resets
    for (int n = 0; n < 400; n++) begin
      logic [3:0] e;
      e = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) e = 4'b0000;
      cyc(e, $urandom, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 49) == 0) begin
        async_reset();
        cyc(4'b1111, $urandom, 1'b0);
        chk("post_rst.m1.owner", o1, 0);
        chk("post_rst.m3.owner", o3, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
